// File: rtl/instr_sequencer.sv
// Four-phase program sequencer (FETCH/DECODE/EXECUTE/RETIRE) with a loadable opcode store.
// Build option: define SEQ_WRAP_EN to wrap pc to 0 after the last address instead of halting.
module instr_sequencer #(
  parameter int PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                load_en,
  input  logic [PC_WIDTH-1:0] load_addr,
  input  logic [3:0]          load_data,
  output logic [3:0]          instruction,
  output logic                exec_valid,
  output logic [1:0]          phase,
  output logic                busy,
  output logic                halted,
  output logic [PC_WIDTH-1:0] pc
);

  localparam int DEPTH = 2 ** PC_WIDTH;
  localparam logic [PC_WIDTH-1:0] PC_LAST = '1;

`ifdef SEQ_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_RETIRE,
    S_HALT
  } state_t;

  state_t     state, state_nxt;
  logic       single;
  logic [3:0] store [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run || step) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE:  state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = S_RETIRE;
      S_RETIRE: begin
        if (!WRAP_EN && pc == PC_LAST) state_nxt = S_HALT;
        else if (run && !single)       state_nxt = S_FETCH;
        else                           state_nxt = S_IDLE;
      end
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // All outputs below decode the state register only; no input-to-output paths.
  always_comb begin
    phase      = 2'd0;
    busy       = 1'b0;
    halted     = 1'b0;
    exec_valid = 1'b0;
    case (state)
      S_FETCH:   begin phase = 2'd0; busy = 1'b1; end
      S_DECODE:  begin phase = 2'd1; busy = 1'b1; end
      S_EXECUTE: begin phase = 2'd2; busy = 1'b1; exec_valid = 1'b1; end
      S_RETIRE:  begin phase = 2'd3; busy = 1'b1; end
      S_HALT:    halted = 1'b1;
      default:   phase = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instruction <= 4'd0;
      single      <= 1'b0;
    end else begin
      if (state == S_IDLE && (run || step))
        single <= step && !run;
      if (state == S_FETCH)
        instruction <= store[pc];
      if (state == S_RETIRE) begin
        single <= 1'b0;
        if (pc != PC_LAST || WRAP_EN)
          pc <= pc + 1'b1;
      end
    end
  end

  // Store survives reset; writes only land while no instruction is in flight.
  always_ff @(posedge clk) begin
    if (load_en && !busy)
      store[load_addr] <= load_data;
  end

endmodule
